// File: rtl/mux_pipelined_nxw_to_1xw.sv
// Pipelined N-input to 1-output word selector.
// Each stage resolves one group of select bits, LSB group first, and narrows
// the candidate set by a factor of 2**BITS_PER_STAGE. The last stage registers
// straight into out_*. Valid, tag and an out-of-range flag travel with the data.
// A single global stall freezes every stage; synchronous reset clears them.
module mux_pipelined_nxw_to_1xw #(
  parameter int WIDTH          = 32,
  parameter int NUM_IN         = 128,
  parameter int SEL_W          = 7,
  parameter int BITS_PER_STAGE = 2,
  parameter int TAG_W          = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_IN*WIDTH-1:0]   in,
  input  logic [SEL_W-1:0]          select,
  input  logic                      in_valid,
  input  logic [TAG_W-1:0]          in_tag,
  input  logic                      stall,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  output logic [TAG_W-1:0]          out_tag,
  output logic                      out_err,
  output logic                      busy
);

  // Pipeline depth: one stage per group of select bits.
  localparam int STAGES  = (SEL_W + BITS_PER_STAGE - 32'sd1) / BITS_PER_STAGE;
  // Input space padded up to a full power of two so every select value
  // addresses a defined word.
  localparam int NUM_PAD = 32'sd1 << SEL_W;

  // Input words padded with zero words for positions NUM_IN..NUM_PAD-1.
  logic [NUM_PAD-1:0][WIDTH-1:0] in_pad_s;
  // Out-of-range flag for the request presented this cycle.
  logic                          in_err_s;
  // Valid bit of every stage, the last one being out_valid.
  logic [STAGES-1:0]             stage_valid_s;

  for (genvar i = 0; i < NUM_PAD; i++) begin : g_pad
    if (i < NUM_IN) begin : g_word
      assign in_pad_s[i] = in[i*WIDTH +: WIDTH];
    end else begin : g_zero
      assign in_pad_s[i] = '0;
    end
  end

  // Flag any select that points past the last real input word.
  always_comb begin
    in_err_s = 1'b0;
    if (int'(select) >= NUM_IN) begin
      in_err_s = 1'b1;
    end else begin
      in_err_s = 1'b0;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Select bits [HI-1:LO] are resolved by this stage.
    localparam int LO      = k * BITS_PER_STAGE;
    localparam int HI      = (LO + BITS_PER_STAGE > SEL_W) ? SEL_W : LO + BITS_PER_STAGE;
    localparam int GB      = HI - LO;
    // Select bits still unresolved when a request enters this stage.
    localparam int SRC_SW  = SEL_W - LO;
    localparam int CNT_IN  = 32'sd1 << SRC_SW;
    localparam int CNT_OUT = 32'sd1 << (SEL_W - HI);
    localparam int GRP     = 32'sd1 << GB;

    // Stage inputs: either the module ports or the previous stage registers.
    logic [CNT_IN-1:0][WIDTH-1:0]  src_cand_s;
    logic [SRC_SW-1:0]             src_sel_s;
    logic                          src_valid_s;
    logic [TAG_W-1:0]              src_tag_s;
    logic                          src_err_s;

    // Narrowed candidate set before and after the stage register.
    logic [CNT_OUT-1:0][WIDTH-1:0] pick_s;
    logic [CNT_OUT-1:0][WIDTH-1:0] nxt_cand_s;
    logic [TAG_W-1:0]              nxt_tag_s;
    logic                          nxt_err_s;
    logic [CNT_OUT-1:0][WIDTH-1:0] cand_r;
    logic [TAG_W-1:0]              tag_r;
    logic                          err_r;
    logic                          valid_r;

    if (k == 0) begin : g_src
      assign src_cand_s  = in_pad_s;
      assign src_sel_s   = select;
      assign src_valid_s = in_valid;
      assign src_tag_s   = in_tag;
      assign src_err_s   = in_err_s;
    end else begin : g_src
      assign src_cand_s  = g_stage[k-1].cand_r;
      assign src_sel_s   = g_stage[k-1].g_carry.sel_r;
      assign src_valid_s = g_stage[k-1].valid_r;
      assign src_tag_s   = g_stage[k-1].tag_r;
      assign src_err_s   = g_stage[k-1].err_r;
    end

    // Candidate j of the output keeps upper index bits j; the low GB bits of
    // the index come from this stage's select group.
    for (genvar j = 0; j < CNT_OUT; j++) begin : g_pick
      logic [SRC_SW-1:0] idx_s;
      assign idx_s     = SRC_SW'(j * GRP) | SRC_SW'(src_sel_s[GB-1:0]);
      assign pick_s[j] = src_cand_s[idx_s];
    end

    // Bubbles load all-zero payload so an idle stage never carries stale data.
    always_comb begin
      nxt_cand_s = '0;
      nxt_tag_s  = '0;
      nxt_err_s  = 1'b0;
      if (src_valid_s) begin
        nxt_cand_s = pick_s;
        nxt_tag_s  = src_tag_s;
        nxt_err_s  = src_err_s;
      end else begin
        nxt_cand_s = '0;
        nxt_tag_s  = '0;
        nxt_err_s  = 1'b0;
      end
    end

    // Stage register: cleared by reset, frozen by stall, otherwise advances.
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_r <= 1'b0;
        cand_r  <= '0;
        tag_r   <= '0;
        err_r   <= 1'b0;
      end else if (!stall) begin
        valid_r <= src_valid_s;
        cand_r  <= nxt_cand_s;
        tag_r   <= nxt_tag_s;
        err_r   <= nxt_err_s;
      end else begin
        valid_r <= valid_r;
        cand_r  <= cand_r;
        tag_r   <= tag_r;
        err_r   <= err_r;
      end
    end

    assign stage_valid_s[k] = valid_r;

    if (k < STAGES - 1) begin : g_carry
      // Upper select bits not yet consumed, handed to the next stage.
      logic [SRC_SW-GB-1:0] sel_r;

      // Carry the unresolved select bits alongside the data.
      always_ff @(posedge clk) begin
        if (rst) begin
          sel_r <= '0;
        end else if (!stall) begin
          if (src_valid_s) begin
            sel_r <= src_sel_s[SRC_SW-1:GB];
          end else begin
            sel_r <= '0;
          end
        end else begin
          sel_r <= sel_r;
        end
      end
    end else begin : g_out
      // The final stage register is the output register.
      assign out_data  = cand_r[0];
      assign out_valid = valid_r;
      assign out_tag   = tag_r;
      assign out_err   = err_r;
    end
  end

  assign busy = |stage_valid_s;

endmodule

// File: tb/tb_mux_pipelined_nxw_to_1xw.sv
// Bench for mux_pipelined_nxw_to_1xw. Four instances share one stimulus:
// defaults, NUM_IN=100, BITS_PER_STAGE=3 and BITS_PER_STAGE=7. The reference
// model logs every request accepted on an unstalled edge; the visible result
// of a configuration with latency L is the entry logged L accepted edges ago.
module tb_mux_pipelined_nxw_to_1xw;

  localparam int W    = 32;
  localparam int N    = 128;
  localparam int SW   = 7;
  localparam int TW   = 6;
  localparam int NCFG = 4;
  localparam int NUMS [NCFG] = '{128, 100, 128, 128};
  localparam int LAT  [NCFG] = '{4, 4, 3, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          in_valid;
  logic          stall;
  logic [SW-1:0] select;
  logic [TW-1:0] in_tag;
  logic [N*W-1:0] in_bus;

  logic [W-1:0]  od [NCFG];
  logic          ov [NCFG];
  logic [TW-1:0] ot [NCFG];
  logic          oe [NCFG];
  logic          ob [NCFG];

  int vectors     = 0;
  int miscompares = 0;

  mux_pipelined_nxw_to_1xw u_dut0 (
    .clk(clk), .rst(rst), .in(in_bus), .select(select), .in_valid(in_valid),
    .in_tag(in_tag), .stall(stall), .out_data(od[0]), .out_valid(ov[0]),
    .out_tag(ot[0]), .out_err(oe[0]), .busy(ob[0]));

  mux_pipelined_nxw_to_1xw #(.NUM_IN(100)) u_dut1 (
    .clk(clk), .rst(rst), .in(in_bus[100*W-1:0]), .select(select), .in_valid(in_valid),
    .in_tag(in_tag), .stall(stall), .out_data(od[1]), .out_valid(ov[1]),
    .out_tag(ot[1]), .out_err(oe[1]), .busy(ob[1]));

  mux_pipelined_nxw_to_1xw #(.BITS_PER_STAGE(3)) u_dut2 (
    .clk(clk), .rst(rst), .in(in_bus), .select(select), .in_valid(in_valid),
    .in_tag(in_tag), .stall(stall), .out_data(od[2]), .out_valid(ov[2]),
    .out_tag(ot[2]), .out_err(oe[2]), .busy(ob[2]));

  mux_pipelined_nxw_to_1xw #(.BITS_PER_STAGE(7)) u_dut3 (
    .clk(clk), .rst(rst), .in(in_bus), .select(select), .in_valid(in_valid),
    .in_tag(in_tag), .stall(stall), .out_data(od[3]), .out_valid(ov[3]),
    .out_tag(ot[3]), .out_err(oe[3]), .busy(ob[3]));

  typedef struct packed {
    logic                   v;
    logic [TW-1:0]          tag;
    logic [NCFG-1:0]        e;
    logic [NCFG-1:0][W-1:0] d;
  } ent_t;

  ent_t hist[$];

  // What a request presented right now should produce in each configuration.
  function automatic ent_t capture();
    ent_t n;
    n = '0;
    if (in_valid) begin
      n.v   = 1'b1;
      n.tag = in_tag;
      for (int c = 0; c < NCFG; c++) begin
        if (int'(select) < NUMS[c]) n.d[c] = in_bus[int'(select)*W +: W];
        else n.e[c] = 1'b1;
      end
    end
    return n;
  endfunction

  // Model bookkeeping: reset forgets everything, stall accepts nothing.
  always @(posedge clk) begin
    if (rst) hist.delete();
    else if (!stall) hist.push_back(capture());
  end

  function automatic ent_t exp_ent(int c);
    if (hist.size() >= LAT[c]) return hist[hist.size() - LAT[c]];
    return '0;
  endfunction

  function automatic logic exp_busy(int c);
    logic b;
    b = 1'b0;
    for (int k = 1; k <= LAT[c]; k++)
      if (hist.size() >= k) b = b | hist[hist.size() - k].v;
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [SW-1:0] s, input logic [TW-1:0] t, input logic st);
    in_valid = v;
    select   = s;
    in_tag   = t;
    stall    = st;
  endtask

  task automatic set_words_const();
    for (int i = 0; i < N; i++) in_bus[i*W +: W] = 32'hA000_0000 + 32'(i);
  endtask

  task automatic set_words_rand();
    for (int i = 0; i < N; i++) in_bus[i*W +: W] = $urandom;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 7'd3, 6'd9, 1'b0);
    tick();
    tick();
    for (int c = 0; c < NCFG; c++) begin
      vectors++;
      if (ov[c] !== 1'b0 || od[c] !== 32'h0 || ot[c] !== 6'd0 || oe[c] !== 1'b0 || ob[c] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset cfg%0d: got v=%b d=%h tag=%h err=%b busy=%b, want all zero", c, ov[c], od[c], ot[c], oe[c], ob[c]);
      end
    end
    rst = 1'b0;
    drive(1'b0, 7'd0, 6'd0, 1'b0);
  endtask

  task automatic test_basic();
    set_words_const();
    for (int n = 1; n <= 8; n++) begin
      if (n == 1) drive(1'b1, 7'd0, 6'd1, 1'b0);
      else if (n == 2) drive(1'b1, 7'd127, 6'd2, 1'b0);
      else drive(1'b0, 7'd0, 6'd0, 1'b0);
      tick();
      vectors++;
      if (ov[0] !== (n == 4 || n == 5)) begin
        miscompares++;
        $display("FAIL basic_valid edge%0d: got %b want %b", n, ov[0], (n == 4 || n == 5));
      end
      if (n == 4) begin
        vectors++;
        if (od[0] !== 32'hA000_0000 || ot[0] !== 6'd1 || oe[0] !== 1'b0) begin
          miscompares++;
          $display("FAIL basic_first: got d=%h tag=%h err=%b want d=a0000000 tag=01 err=0", od[0], ot[0], oe[0]);
        end
      end
      if (n == 5) begin
        vectors++;
        if (od[0] !== 32'hA000_007F || ot[0] !== 6'd2 || oe[0] !== 1'b0) begin
          miscompares++;
          $display("FAIL basic_second: got d=%h tag=%h err=%b want d=a000007f tag=02 err=0", od[0], ot[0], oe[0]);
        end
      end
    end
  endtask

  task automatic test_short_pipes();
    set_words_const();
    for (int n = 1; n <= 6; n++) begin
      if (n == 1) drive(1'b1, 7'd0, 6'd1, 1'b0);
      else if (n == 2) drive(1'b1, 7'd127, 6'd2, 1'b0);
      else drive(1'b0, 7'd0, 6'd0, 1'b0);
      tick();
      vectors++;
      if (ov[2] !== (n == 3 || n == 4) || ov[3] !== (n == 1 || n == 2)) begin
        miscompares++;
        $display("FAIL short_valid edge%0d: got b3=%b b7=%b want b3=%b b7=%b", n, ov[2], ov[3], (n == 3 || n == 4), (n == 1 || n == 2));
      end
      if (n == 3 || n == 1) begin
        vectors++;
        if (od[n == 3 ? 2 : 3] !== 32'hA000_0000 || ot[n == 3 ? 2 : 3] !== 6'd1) begin
          miscompares++;
          $display("FAIL short_first edge%0d: got d=%h tag=%h want d=a0000000 tag=01", n, od[n == 3 ? 2 : 3], ot[n == 3 ? 2 : 3]);
        end
      end
      if (n == 4 || n == 2) begin
        vectors++;
        if (od[n == 4 ? 2 : 3] !== 32'hA000_007F || ot[n == 4 ? 2 : 3] !== 6'd2) begin
          miscompares++;
          $display("FAIL short_second edge%0d: got d=%h tag=%h want d=a000007f tag=02", n, od[n == 4 ? 2 : 3], ot[n == 4 ? 2 : 3]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int first_n;
    int last_n;
    int run;
    ent_t e;
    first_n = -1;
    last_n  = -1;
    run     = 0;
    set_words_const();
    for (int i = 0; i < N + 8; i++) begin
      if (i < N) drive(1'b1, 7'(i), 6'(i), 1'b0);
      else drive(1'b0, 7'd0, 6'd0, 1'b0);
      tick();
      if (ov[0] === 1'b1) begin
        if (first_n < 0) first_n = i + 1;
        last_n = i + 1;
        vectors++;
        if (od[0] !== 32'hA000_0000 + 32'(run)) begin
          miscompares++;
          $display("FAIL b2b_data #%0d: got %h want %h", run, od[0], 32'hA000_0000 + 32'(run));
        end
        run++;
      end
      e = exp_ent(0);
      vectors++;
      if (ov[0] !== e.v || od[0] !== e.d[0] || ot[0] !== e.tag || oe[0] !== e.e[0] || ob[0] !== exp_busy(0)) begin
        miscompares++;
        $display("FAIL b2b_model edge%0d: got v=%b d=%h tag=%h, want v=%b d=%h tag=%h", i + 1, ov[0], od[0], ot[0], e.v, e.d[0], e.tag);
      end
    end
    vectors++;
    if (first_n !== 4 || run !== 128 || last_n - first_n + 1 !== run) begin
      miscompares++;
      $display("FAIL b2b_stream: got first=%0d count=%0d span=%0d want first=4 count=128 span=128", first_n, run, last_n - first_n + 1);
    end
  endtask

  task automatic test_out_of_range();
    set_words_const();
    for (int n = 1; n <= 8; n++) begin
      if (n == 1) drive(1'b1, 7'd100, 6'd10, 1'b0);
      else if (n == 2) drive(1'b1, 7'd127, 6'd11, 1'b0);
      else if (n == 3) drive(1'b1, 7'd99, 6'd12, 1'b0);
      else drive(1'b0, 7'd0, 6'd0, 1'b0);
      tick();
      if (n == 4 || n == 5) begin
        vectors++;
        if (ov[1] !== 1'b1 || oe[1] !== 1'b1 || od[1] !== 32'h0 || ot[1] !== (n == 4 ? 6'd10 : 6'd11)) begin
          miscompares++;
          $display("FAIL oor_edge%0d: got v=%b err=%b d=%h tag=%h want v=1 err=1 d=0 tag=%h", n, ov[1], oe[1], od[1], ot[1], (n == 4 ? 6'd10 : 6'd11));
        end
      end
      if (n == 6) begin
        vectors++;
        if (ov[1] !== 1'b1 || oe[1] !== 1'b0 || od[1] !== 32'hA000_0063 || ot[1] !== 6'd12) begin
          miscompares++;
          $display("FAIL oor_in_range: got v=%b err=%b d=%h tag=%h want v=1 err=0 d=a0000063 tag=0c", ov[1], oe[1], od[1], ot[1]);
        end
      end
    end
  endtask

  task automatic test_stall();
    int req;
    logic [W-1:0]  p_d;
    logic          p_v;
    logic [TW-1:0] p_t;
    logic          was_stall;
    logic [TW-1:0] got[$];
    ent_t e;
    req = 0;
    for (int cy = 0; cy < 20; cy++) begin
      p_d = od[0]; p_v = ov[0]; p_t = ot[0];
      set_words_rand();
      was_stall = (cy >= 4 && cy <= 6);
      if (was_stall) drive(1'b1, 7'($urandom), 6'd40 + 6'(cy), 1'b1);
      else if (req < 8) begin
        drive(1'b1, 7'($urandom), 6'(req + 1), 1'b0);
        req++;
      end else drive(1'b0, 7'd0, 6'd0, 1'b0);
      tick();
      if (was_stall) begin
        vectors++;
        if (od[0] !== p_d || ov[0] !== p_v || ot[0] !== p_t) begin
          miscompares++;
          $display("FAIL stall_hold cy%0d: got v=%b d=%h tag=%h want v=%b d=%h tag=%h", cy, ov[0], od[0], ot[0], p_v, p_d, p_t);
        end
      end else if (ov[0] === 1'b1) got.push_back(ot[0]);
      for (int c = 0; c < 2; c++) begin
        e = exp_ent(c);
        vectors++;
        if (ov[c] !== e.v || od[c] !== e.d[c] || ot[c] !== e.tag || oe[c] !== e.e[c] || ob[c] !== exp_busy(c)) begin
          miscompares++;
          $display("FAIL stall_model cfg%0d cy%0d: got v=%b d=%h tag=%h err=%b, want v=%b d=%h tag=%h err=%b", c, cy, ov[c], od[c], ot[c], oe[c], e.v, e.d[c], e.tag, e.e[c]);
        end
      end
    end
    stall = 1'b0;
    vectors++;
    if (got.size() != 8) begin
      miscompares++;
      $display("FAIL stall_count: got %0d results want 8", got.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        vectors++;
        if (got[i] !== 6'(i + 1)) begin
          miscompares++;
          $display("FAIL stall_order #%0d: got tag %h want %h", i, got[i], 6'(i + 1));
        end
      end
    end
  endtask

  task automatic test_reset_flush();
    set_words_const();
    for (int n = 1; n <= 3; n++) begin
      drive(1'b1, 7'(n + 4), 6'(n + 2), 1'b0);
      tick();
    end
    rst = 1'b1;
    drive(1'b1, 7'd9, 6'd6, 1'b0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < NCFG; c++) begin
      vectors++;
      if (ov[c] !== 1'b0 || od[c] !== 32'h0 || ot[c] !== 6'd0 || oe[c] !== 1'b0 || ob[c] !== 1'b0) begin
        miscompares++;
        $display("FAIL flush_after_reset cfg%0d: got v=%b d=%h tag=%h err=%b busy=%b want all zero", c, ov[c], od[c], ot[c], oe[c], ob[c]);
      end
    end
    drive(1'b0, 7'd0, 6'd0, 1'b0);
    for (int n = 0; n < 6; n++) begin
      tick();
      for (int c = 0; c < NCFG; c++) begin
        vectors++;
        if (ov[c] !== 1'b0 || ob[c] !== 1'b0) begin
          miscompares++;
          $display("FAIL flush_idle cfg%0d cy%0d: got v=%b busy=%b want 0 0", c, n, ov[c], ob[c]);
        end
      end
    end
  endtask

  task automatic test_random();
    ent_t e;
    for (int cy = 0; cy < 500; cy++) begin
      set_words_rand();
      rst = ($urandom_range(0, 39) == 0);
      drive($urandom_range(0, 3) != 0, 7'($urandom), 6'($urandom), $urandom_range(0, 3) == 0);
      tick();
      for (int c = 0; c < NCFG; c++) begin
        e = exp_ent(c);
        vectors++;
        if (ov[c] !== e.v || od[c] !== e.d[c] || ot[c] !== e.tag || oe[c] !== e.e[c] || ob[c] !== exp_busy(c)) begin
          miscompares++;
          $display("FAIL random cfg%0d cy%0d: got v=%b d=%h tag=%h err=%b busy=%b, want v=%b d=%h tag=%h err=%b busy=%b", c, cy, ov[c], od[c], ot[c], oe[c], ob[c], e.v, e.d[c], e.tag, e.e[c], exp_busy(c));
        end
      end
    end
    rst = 1'b0;
    drive(1'b0, 7'd0, 6'd0, 1'b0);
  endtask

  initial begin
    rst      = 1'b1;
    stall    = 1'b0;
    in_valid = 1'b0;
    select   = '0;
    in_tag   = '0;
    in_bus   = '0;
    test_reset();
    test_basic();
    test_short_pipes();
    test_back_to_back();
    test_out_of_range();
    test_stall();
    test_reset_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mux_pipelined_nxw_to_1xw.md
Name: mux_pipelined_nxw_to_1xw

Overview:
- Parametrised, pipelined N-input to 1-output word selector.
- Successor to the flat 128x32b combinational mux used in the register-file and operand read paths.
- Resolves the select a few bits per stage, so wide fan-in selections (e.g. 128 or 256 lanes) close timing on FPGA builds.
- Carries valid, tag and out-of-range error alongside the data, with a global stall to hold the pipe.

Parameters:
- WIDTH, 32: bits per input word and per output word.
- NUM_IN, 128: number of input words; any value from 2 to 2^SEL_W.
- SEL_W, 7: select width.
- BITS_PER_STAGE, 2: select bits resolved per pipeline stage (1..SEL_W).
- TAG_W, 6: width of the sideband tag carried with each request.
- STAGES, derived, ceil(SEL_W/BITS_PER_STAGE): pipeline depth. Not user-set.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in  input  NUM_IN*WIDTH  packed inputs; word i occupies bits [WIDTH*i+WIDTH-1 : WIDTH*i].
- select  input  SEL_W  index of the word to forward.
- in_valid  input  1  request present this cycle.
- in_tag  input  TAG_W  sideband tag, returned unchanged with the result.
- stall  input  1  hold the entire pipeline.
- out_data  output  WIDTH  selected word (registered).
- out_valid  output  1  out_data, out_tag and out_err are meaningful.
- out_tag  output  TAG_W  tag of the returned request.
- out_err  output  1  select was >= NUM_IN.
- busy  output  1  at least one valid request is in flight in any stage, including the output stage.

Behaviour:
- Reset (rst=1 at an edge): all stage valids, out_valid, out_data, out_tag and out_err clear to 0 on that edge.
  - Reset dominates stall and in_valid.
  - In-flight requests are discarded, never emitted.
  - busy is 0 on the cycle after reset.
- Capture: on an edge with rst=0 and stall=0, stage 0 samples in, select, in_valid and in_tag.
  - in must be stable only in the capture cycle; later stages hold partially selected data internally.
  - Requests presented while stall=1 are not captured.
- Selection: stage k narrows the candidate set using select bits [min(SEL_W, (k+1)*BITS_PER_STAGE)-1 : k*BITS_PER_STAGE], LSB group first.
  - Untouched select bits and the tag travel with the data.
  - The final stage registers directly into out_*.
  - Internal structure is free, provided latency and results match this spec.
- Latency: with stall held 0, a request captured at edge T appears on out_* after edge T+STAGES-1.
  - Defaults: STAGES=4, so out_valid is high 4 cycles after in_valid is presented.
  - Throughput is one request per cycle.
- Stall: stall=1 with rst=0 holds every stage register, including out_*, unchanged; nothing is captured or dropped. out_valid may therefore stay high for multiple cycles with the same result.
- Bubbles: a stage loaded with valid=0 also loads data=0, tag=0 and err=0.
  - Consequence: out_valid=0 implies out_data=0, out_tag=0 and out_err=0.
- Out of range: if select >= NUM_IN (only possible when NUM_IN < 2^SEL_W):
  - out_data=0 and out_err=1 are returned, with out_valid=1 and the tag preserved.
  - No X is ever produced.
- Non-power-of-2 NUM_IN: missing input positions are treated as zero words and flagged by out_err.
- busy = OR of all stage valids and out_valid.
- Width rules: out_data is exactly WIDTH bits; no sign or zero extension is applied to the selected word.

Test Plan:
- Defaults, word i = 32'hA000_0000+i, one request with select=7'd0, then one with select=7'd127 (tags 1, 2) -> out_data 32'hA000_0000 then 32'hA000_007F; out_tag 1 then 2; out_valid high exactly 4 and 5 cycles after the first request; out_err=0.
- Back-to-back requests for select 0..127 with stall=0 -> 128 consecutive out_valid cycles, out_data=word i in order, first result 4 cycles after the first request.
- Stream of 8 requests with stall=1 for 3 cycles mid-stream -> out_* held constant during the stall; all 8 results in order, none lost or duplicated; requests presented during the stall are not captured.
- NUM_IN=100, SEL_W=7, select=7'd100 and select=7'd127 -> out_valid=1, out_err=1, out_data=0, tag preserved; select=7'd99 -> word 99, out_err=0.
- rst asserted for one cycle while 3 requests are in flight -> no out_valid afterwards for those requests; out_* all 0 and busy=0 the cycle after reset.
- BITS_PER_STAGE=3, SEL_W=7 (STAGES=3) and BITS_PER_STAGE=7 (STAGES=1) -> latency 3 and 1 respectively, with the same data and tag checks as the first scenario.
